// File: rtl/wh_noc_pkg.sv
// Shared flit-type encodings, scheduler state encoding and flit classification helpers
// for the wormhole mesh node.
package wh_noc_pkg;

  localparam int unsigned FLIT_ID_W = 2;

  localparam logic [FLIT_ID_W-1:0] FLIT_BODY   = 2'b00;
  localparam logic [FLIT_ID_W-1:0] FLIT_TAIL   = 2'b01;
  localparam logic [FLIT_ID_W-1:0] FLIT_HEAD   = 2'b10;
  localparam logic [FLIT_ID_W-1:0] FLIT_SINGLE = 2'b11;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // A SINGLE flit both opens and closes a packet.
  function automatic logic is_head_f(input logic [FLIT_ID_W-1:0] fid);
    return (fid == FLIT_HEAD) || (fid == FLIT_SINGLE);
  endfunction

  function automatic logic is_tail_f(input logic [FLIT_ID_W-1:0] fid);
    return (fid == FLIT_TAIL) || (fid == FLIT_SINGLE);
  endfunction

endpackage

// File: rtl/wh_rr_arbiter.sv
// Combinational rotate-priority picker: first set request scanning ptr+1, ptr+2, ... mod IN_N.
module wh_rr_arbiter #(
  parameter int unsigned IN_N  = 5,
  parameter int unsigned SEL_W = (IN_N > 1) ? $clog2(IN_N) : 1
) (
  input  logic [IN_N-1:0]  req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] winner_o,
  output logic             any_req_o
);

  logic [SEL_W-1:0] idx;

  // Scan farthest-first so the nearest requester after ptr overwrites the rest.
  always_comb begin
    winner_o  = '0;
    idx       = '0;
    any_req_o = |req_i;
    for (int unsigned off = IN_N; off >= 1; off--) begin
      idx = SEL_W'((32'(ptr_i) + off) % IN_N);
      if (req_i[idx]) winner_o = idx;
    end
  end

endmodule

// File: rtl/wh_out_chan_scheduler.sv
// Per-output-port wormhole scheduler: round-robin grant on HEAD/SINGLE, lock until TAIL/SINGLE.
// Optional sticky stall timeout enabled by defining WH_SCHED_TIMEOUT_EN.
module wh_out_chan_scheduler
  import wh_noc_pkg::*;
#(
  parameter int unsigned IN_N        = 5,
  parameter int unsigned OUT_M       = 5,
  parameter int unsigned FLIT_ID_W   = wh_noc_pkg::FLIT_ID_W,
  parameter int unsigned OUT_CHAN_ID = 0,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [IN_N*((OUT_M > 1) ? $clog2(OUT_M) : 1)-1:0] rtr_res_i,
  input  logic [IN_N-1:0]                        rtr_res_vld_i,
  input  logic [IN_N*FLIT_ID_W-1:0]              flit_id_i,
  input  logic [IN_N-1:0]                        data_vld_i,
  input  logic                                   fwd_rdy_i,
  output logic [((IN_N > 1) ? $clog2(IN_N) : 1)-1:0] sel_o,
  output logic                                   out_vld_o,
  output logic [IN_N-1:0]                        chan_alloc_o,
  output logic                                   busy_o,
  output logic                                   timeout_o
);

  localparam int unsigned RT_W  = (OUT_M > 1) ? $clog2(OUT_M) : 1;
  localparam int unsigned SEL_W = (IN_N > 1) ? $clog2(IN_N) : 1;

  logic [0:0]           state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic [IN_N-1:0]      alloc_q, alloc_d;
  logic                 busy_q, busy_d;

  logic [FLIT_ID_W-1:0] fid [IN_N];
  logic [IN_N-1:0]      req;
  logic [SEL_W-1:0]     winner;
  logic                 any_req;
  logic                 xfer;

  for (genvar g = 0; g < IN_N; g++) begin : g_in
    assign fid[g] = flit_id_i[g*FLIT_ID_W +: FLIT_ID_W];
    assign req[g] = data_vld_i[g] & rtr_res_vld_i[g]
                  & (rtr_res_i[g*RT_W +: RT_W] == RT_W'(OUT_CHAN_ID))
                  & is_head_f(fid[g]);
  end

  wh_rr_arbiter #(
    .IN_N  (IN_N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // Transfer is gated off during reset so a dying lock forwards nothing.
  assign xfer      = (state_q == ST_LOCKED) & data_vld_i[sel_q] & fwd_rdy_i & ~rst_i;
  assign out_vld_o = xfer;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    alloc_d = alloc_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_LOCKED;
          ptr_d   = winner;
          sel_d   = winner;
          alloc_d = IN_N'(1) << winner;
          busy_d  = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (xfer && is_tail_f(fid[sel_q])) begin
          state_d = ST_IDLE;
          alloc_d = '0;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        alloc_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= SEL_W'(IN_N - 1);
      sel_q   <= '0;
      alloc_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      alloc_q <= alloc_d;
      busy_q  <= busy_d;
    end
  end

  assign sel_o        = sel_q;
  assign chan_alloc_o = alloc_q;
  assign busy_o       = busy_q;

`ifdef WH_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;

  // Counts consecutive stalled locked cycles; saturates, never breaks the lock.
  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if ((state_q == ST_LOCKED) && !xfer) begin
      if (cnt_q != CNT_W'(TIMEOUT_CYC)) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_W'(TIMEOUT_CYC)) to_d = 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end

  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif

endmodule
